// File: rtl/alu_muldiv_if.sv
// Request/response bundle for alu_muldiv_unit.
// The master drives start, op, a, b and flush. The slave returns the handshake flags and the results.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result, result_hi, zero, div_by_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result, result_hi, zero, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Execute-stage arithmetic unit.
// The eight single-cycle ALU operations complete with latency 1.
// Multiply and divide, signed and unsigned, iterate for WIDTH cycles.
// Build option FAST_MUL_EN: ops 8 and 9 use a combinational multiplier and complete with latency 1.
module alu_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_d;
    logic               accept_c, step_c, last_c, slow_c;
    logic               a_neg_c, b_neg_c;
    logic [WIDTH-1:0]   a_mag_c, b_mag_c;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc, mq, dvsr, a_q;
    logic               is_div, neg_res, neg_rem, dbz;
    logic [WIDTH:0]     mul_sum_c, rem_sh_c, rem_diff_c;
    logic [WIDTH-1:0]   acc_n_c, mq_n_c;
    logic [PW-1:0]      prod_c, prod_fix_c;
    logic [WIDTH-1:0]   fin_lo_c, fin_hi_c;
    logic [WIDTH-1:0]   alu_res_c, alu_hi_c;
    logic               alu_zero_c;

`ifdef FAST_MUL_EN
    logic [PW-1:0]      up_c, sp_c;
    assign slow_c = (bus.op[3:1] == 3'b101);
    assign up_c   = PW'(bus.a) * PW'(bus.b);
    assign sp_c   = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
`else
    assign slow_c = (bus.op[3:2] == 2'b10);
`endif

    // Operand magnitudes; odd slow opcodes (muls, divs) are the signed variants
    assign a_neg_c = bus.op[0] & bus.a[WIDTH-1];
    assign b_neg_c = bus.op[0] & bus.b[WIDTH-1];
    assign a_mag_c = a_neg_c ? -bus.a : bus.a;
    assign b_mag_c = b_neg_c ? -bus.b : bus.b;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next state and step control; flush wins over start
    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start && !bus.flush) begin
                    accept_c = 1'b1;
                    state_d  = slow_c ? RUN : DONE;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    step_c = 1'b1;
                    if (cnt == '0) begin
                        last_c  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One shift-add multiply step or one restoring-divide step
    always_comb begin
        mul_sum_c  = {1'b0, acc} + (mq[0] ? {1'b0, dvsr} : '0);
        rem_sh_c   = {acc, mq[WIDTH-1]};
        rem_diff_c = rem_sh_c - {1'b0, dvsr};
        if (is_div) begin
            if (!rem_diff_c[WIDTH]) begin
                acc_n_c = rem_diff_c[WIDTH-1:0];
                mq_n_c  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_n_c = rem_sh_c[WIDTH-1:0];
                mq_n_c  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n_c = mul_sum_c[WIDTH:1];
            mq_n_c  = {mul_sum_c[0], mq[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the final step; divide by zero overrides the magnitude result
    always_comb begin
        prod_c     = {acc_n_c, mq_n_c};
        prod_fix_c = neg_res ? -prod_c : prod_c;
        if (is_div) begin
            if (dbz) begin
                fin_lo_c = '1;
                fin_hi_c = a_q;
            end else begin
                fin_lo_c = neg_res ? -mq_n_c : mq_n_c;
                fin_hi_c = neg_rem ? -acc_n_c : acc_n_c;
            end
        end else begin
            fin_lo_c = prod_fix_c[WIDTH-1:0];
            fin_hi_c = prod_fix_c[PW-1:WIDTH];
        end
    end

    // Single-cycle operations; unused opcodes fall back to add
    always_comb begin
        alu_res_c = bus.a + bus.b;
        alu_hi_c  = '0;
        case (bus.op)
            4'd1: alu_res_c = bus.a - bus.b;
            4'd2: alu_res_c = bus.a & bus.b;
            4'd3: alu_res_c = bus.a | bus.b;
            4'd4: alu_res_c = bus.a ^ bus.b;
            4'd5: alu_res_c = ~(bus.a | bus.b);
            4'd6: alu_res_c = WIDTH'($signed(bus.a) < $signed(bus.b));
            4'd7: alu_res_c = WIDTH'(bus.a != bus.b);
`ifdef FAST_MUL_EN
            4'd8: {alu_hi_c, alu_res_c} = up_c;
            4'd9: {alu_hi_c, alu_res_c} = sp_c;
`endif
            default: alu_res_c = bus.a + bus.b;
        endcase
        alu_zero_c = (bus.op == 4'd7) ? (bus.a != bus.b) : (alu_res_c == '0);
    end

    // Datapath and output registers; results change only when an operation completes
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt             <= '0;
            acc             <= '0;
            mq              <= '0;
            dvsr            <= '0;
            a_q             <= '0;
            is_div          <= 1'b0;
            neg_res         <= 1'b0;
            neg_rem         <= 1'b0;
            dbz             <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.result_hi   <= '0;
            bus.zero        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.busy <= (state_d == RUN);
            bus.done <= (state_d == DONE);
            if (accept_c) begin
                if (slow_c) begin
                    cnt     <= CNT_W'(WIDTH - 1);
                    acc     <= '0;
                    mq      <= a_mag_c;
                    dvsr    <= b_mag_c;
                    a_q     <= bus.a;
                    is_div  <= bus.op[1];
                    neg_res <= a_neg_c ^ b_neg_c;
                    neg_rem <= a_neg_c;
                    dbz     <= bus.op[1] && (bus.b == '0);
                end else begin
                    bus.result      <= alu_res_c;
                    bus.result_hi   <= alu_hi_c;
                    bus.zero        <= alu_zero_c;
                    bus.div_by_zero <= 1'b0;
                end
            end
            if (step_c) begin
                acc <= acc_n_c;
                mq  <= mq_n_c;
                cnt <= cnt - CNT_W'(1);
            end
            if (last_c) begin
                bus.result      <= fin_lo_c;
                bus.result_hi   <= fin_hi_c;
                bus.zero        <= (fin_lo_c == '0);
                bus.div_by_zero <= dbz;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit. It uses a scoreboard of expected results and an independent reference model.
module tb_alu_muldiv_unit;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         dbz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_slow(input logic [3:0] op);
`ifdef FAST_MUL_EN
        return (op == 4'd10) || (op == 4'd11);
`else
        return (op >= 4'd8) && (op <= 4'd11);
`endif
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        e = '0;
        case (op)
            4'd1: e.res = a - b;
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = ~(a | b);
            4'd6: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7: e.res = (a != b) ? 32'd1 : 32'd0;
            4'd8: begin
                p = 64'(a) * 64'(b);
                e.res = p[31:0];
                e.hi = p[63:32];
            end
            4'd9: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                e.res = p[31:0];
                e.hi = p[63:32];
            end
            4'd10: begin
                if (b == 0) begin
                    e.res = '1;
                    e.hi = a;
                    e.dbz = 1'b1;
                end else begin
                    e.res = a / b;
                    e.hi = a % b;
                end
            end
            4'd11: begin
                if (b == 0) begin
                    e.res = '1;
                    e.hi = a;
                    e.dbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.res = 32'h8000_0000;
                    e.hi = '0;
                end else begin
                    e.res = 32'($signed(a) / $signed(b));
                    e.hi = 32'($signed(a) % $signed(b));
                end
            end
            default: e.res = a + b;
        endcase
        e.zero = (op == 4'd7) ? (a != b) : (e.res == 0);
        return e;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e);
        chk({tag, " result"}, 64'(bus.result), 64'(e.res));
        chk({tag, " result_hi"}, 64'(bus.result_hi), 64'(e.hi));
        chk({tag, " zero"}, 64'(bus.zero), 64'(e.zero));
        chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(e.dbz));
    endtask

    // Issue one operation, wait for done with a bound, and check latency, busy time and results
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int   lat, nbusy, exp_lat;
        exp_t e;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        sb.push_back(model(op, a, b));
        exp_lat = is_slow(op) ? int'(W) + 1 : 1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        nbusy = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.busy === 1'b1) nbusy++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(nbusy), 64'(exp_lat - 1));
        e = sb.pop_front();
        last = e;
        cmp_out(tag, e);
    endtask

    // Long divide with ignored start pulses in cycles 3..5; mode 0 completes, mode 1 flushes and mode 2 resets at cycle 10
    task automatic run_abort(input int mode);
        exp_t prior, e;
        int   lat, ndone;
        prior = last;
        bus.start = 1'b1;
        bus.op = 4'd10;
        bus.a = 32'd100;
        bus.b = 32'd7;
        if (mode == 0) sb.push_back(model(4'd10, 32'd100, 32'd7));
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            bus.start = (c >= 3 && c <= 5);
            bus.op = 4'd0;
            bus.a = 32'd1;
            bus.b = 32'd1;
            bus.flush = (mode == 1 && c == 10);
            reset = (mode == 2 && c == 10);
            tick();
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
        reset = 1'b0;
        if (mode == 0) begin
            lat = 11;
            while (bus.done !== 1'b1 && lat < 60) begin
                tick();
                lat++;
            end
            chk("ignored-start latency", 64'(lat), 64'(W + 1));
            e = sb.pop_front();
            last = e;
            cmp_out("ignored-start", e);
        end else begin
            e = (mode == 1) ? prior : exp_t'('0);
            chk(mode == 1 ? "flush busy" : "reset busy", 64'(bus.busy), 64'(0));
            cmp_out(mode == 1 ? "flush hold" : "reset clear", e);
            ndone = 0;
            for (int i = 0; i < 40; i++) begin
                if (bus.done === 1'b1) ndone++;
                tick();
            end
            chk(mode == 1 ? "flush no done" : "reset no done", 64'(ndone), 64'(0));
            cmp_out(mode == 1 ? "flush late hold" : "reset late", e);
            last = e;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 4'd0;
        bus.a = '0;
        bus.b = '0;
        bus.flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset done", 64'(bus.done), 64'(0));
        cmp_out("reset", exp_t'('0));

        run_op("add wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
        run_op("sub", 4'd1, 32'd3, 32'd5);
        run_op("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
        run_op("or", 4'd3, 32'hF000_0001, 32'h0000_1000);
        run_op("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000);
        run_op("nor", 4'd5, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
        run_op("slt neg", 4'd6, 32'hFFFF_FFFF, 32'd1);
        run_op("slt pos", 4'd6, 32'd5, 32'hFFFF_FFFD);
        run_op("sne eq", 4'd7, 32'd9, 32'd9);
        run_op("sne ne", 4'd7, 32'd9, 32'd8);
        run_op("op13 add", 4'd13, 32'd40, 32'd2);
        run_op("mulu max", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("muls", 4'd9, 32'hFFFF_FFFD, 32'd5);
        run_op("divs -7/2", 4'd11, 32'hFFFF_FFF9, 32'd2);
        run_op("divu by 0", 4'd10, 32'd5, 32'd0);
        run_op("divs min/-1", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu", 4'd10, 32'd100, 32'd7);
        run_op("divs 7/-2", 4'd11, 32'd7, 32'hFFFF_FFFE);
        run_op("divs -7/0", 4'd11, 32'hFFFF_FFF9, 32'd0);

        tick();
        chk("hold done", 64'(bus.done), 64'(0));
        cmp_out("hold", last);

        run_op("pre-drop add", 4'd0, 32'd1, 32'd2);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op = 4'd0;
        bus.a = 32'd7;
        bus.b = 32'd7;
        tick();
        chk("drop in done", 64'(bus.done), 64'(0));
        tick();
        chk("drop in idle", 64'(bus.done), 64'(0));
        chk("drop busy", 64'(bus.busy), 64'(0));
        bus.start = 1'b0;
        bus.flush = 1'b0;
        cmp_out("drop hold", last);

        run_abort(0);
        run_abort(1);
        run_abort(2);
        run_op("after reset mulu", 4'd8, 32'h0001_0000, 32'h0003_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
